// File: rtl/snake_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module   : snake_pixel_renderer
// Brief    : Snake body, movement and hit detection, plus per-state RGB444
//            pixel colour for the VGA stage (160x120 grid of 4x4 cells).
//            Optional macro SNAKE_WIN_ANIM_EN animates the WIN screen.
// Revision : 1.0
// ============================================================================
module snake_pixel_renderer #(
    parameter int MAX_LENGTH   = 32,
    parameter int START_LENGTH = 4,
    parameter int MOVE_PERIOD  = 5_000_000,
    parameter int START_X      = 80,
    parameter int START_Y      = 60
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [1:0]  MSM_STATE,
    input  logic [1:0]  NAV_STATE,
    input  logic [7:0]  TARGET_X,
    input  logic [6:0]  TARGET_Y,
    input  logic [9:0]  ADDRH,
    input  logic [9:0]  ADDRY,
    output logic [11:0] COLOUR_OUT,
    output logic        TARGET_REACHED,
    output logic        SELF_HIT
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_PLAY   = 2'b01;
    localparam logic [1:0] ST_WIN    = 2'b10;
    localparam logic [1:0] ST_LOSE   = 2'b11;
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam int              CNT_W     = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int              LEN_W     = $clog2(MAX_LENGTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);
    localparam logic [LEN_W-1:0] LEN_START = LEN_W'(START_LENGTH);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LENGTH);
    localparam logic [7:0]       X_LAST    = 8'd159;
    localparam logic [6:0]       Y_LAST    = 7'd119;
    localparam logic [6:0]       Y_START   = 7'(START_Y);

    // Body laid out leftwards from the start head, wrapping around the grid.
    function automatic logic [7:0] init_x(input int idx);
        return 8'((START_X + 160 * (idx / 160 + 1) - idx) % 160);
    endfunction

    logic [7:0]       seg_x_q [MAX_LENGTH];
    logic [7:0]       seg_x_d [MAX_LENGTH];
    logic [6:0]       seg_y_q [MAX_LENGTH];
    logic [6:0]       seg_y_d [MAX_LENGTH];
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      colour_q, colour_d;
    logic             target_q, target_d;
    logic             self_hit_q, self_hit_d;
`ifdef SNAKE_WIN_ANIM_EN
    logic [3:0]       anim_q, anim_d;
`endif

    logic       cnt_run;
    logic       step;
    logic [1:0] nav_dir;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic       hit_target;
    logic       hit_self;
    logic [7:0] cell_x;
    logic [6:0] cell_y;
    logic       body_hit;

    always_comb begin
        nav_dir = (NAV_STATE == (dir_q ^ 2'b10)) ? dir_q : NAV_STATE;
        head_x  = seg_x_q[0];
        head_y  = seg_y_q[0];
        case (nav_dir)
            DIR_UP:    head_y = (seg_y_q[0] == 7'd0)  ? Y_LAST : seg_y_q[0] - 7'd1;
            DIR_RIGHT: head_x = (seg_x_q[0] == X_LAST) ? 8'd0  : seg_x_q[0] + 8'd1;
            DIR_DOWN:  head_y = (seg_y_q[0] == Y_LAST) ? 7'd0  : seg_y_q[0] + 7'd1;
            DIR_LEFT:  head_x = (seg_x_q[0] == 8'd0)  ? X_LAST : seg_x_q[0] - 8'd1;
        endcase
        hit_target = (head_x == TARGET_X) && (head_y == TARGET_Y);
        // The tail cell vacates on this step, so only indices up to length-2 count.
        hit_self = 1'b0;
        for (int i = 0; i < MAX_LENGTH - 1; i++) begin
            if ((i + 1) < int'(len_q) && seg_x_q[i] == head_x && seg_y_q[i] == head_y) begin
                hit_self = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef SNAKE_WIN_ANIM_EN
        cnt_run = (MSM_STATE == ST_PLAY) || (MSM_STATE == ST_WIN);
`else
        cnt_run = (MSM_STATE == ST_PLAY);
`endif
        step = (MSM_STATE == ST_PLAY) && (cnt_q == CNT_LAST);
    end

    always_comb begin
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        target_d   = 1'b0;
        self_hit_d = 1'b0;
`ifdef SNAKE_WIN_ANIM_EN
        anim_d     = anim_q;
`endif
        if (MSM_STATE == ST_IDLE) begin
            for (int i = 0; i < MAX_LENGTH; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = Y_START;
            end
            len_d = LEN_START;
            dir_d = DIR_RIGHT;
            cnt_d = '0;
`ifdef SNAKE_WIN_ANIM_EN
            anim_d = 4'd0;
`endif
        end else begin
            if (cnt_run) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
`ifdef SNAKE_WIN_ANIM_EN
                if (cnt_q == CNT_LAST) begin
                    anim_d = anim_q + 4'd1;
                end
`endif
            end
            if (step) begin
                dir_d = nav_dir;
                for (int i = 1; i < MAX_LENGTH; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = head_x;
                seg_y_d[0] = head_y;
                target_d   = hit_target;
                self_hit_d = hit_self;
                if (hit_target && len_q != LEN_MAX) begin
                    len_d = len_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cell_x   = ADDRH[9:2];
        cell_y   = ADDRY[8:2];
        body_hit = 1'b0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if (i < int'(len_q) && seg_x_q[i] == cell_x && seg_y_q[i] == cell_y) begin
                body_hit = 1'b1;
            end
        end
        colour_d = 12'h000;
        if (ADDRH < 10'd640 && ADDRY < 10'd480) begin
            case (MSM_STATE)
                ST_IDLE: colour_d = 12'h00F;
                ST_PLAY: begin
                    if (body_hit) begin
                        colour_d = 12'hFF0;
                    end else if (cell_x == TARGET_X && cell_y == TARGET_Y) begin
                        colour_d = 12'hF00;
                    end else begin
                        colour_d = 12'h0F0;
                    end
                end
`ifdef SNAKE_WIN_ANIM_EN
                ST_WIN:  colour_d = {anim_q, ADDRH[7:4], ADDRY[7:4]};
`else
                ST_WIN:  colour_d = 12'hFFF;
`endif
                ST_LOSE: colour_d = 12'hF00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < MAX_LENGTH; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= Y_START;
            end
            len_q      <= LEN_START;
            dir_q      <= DIR_RIGHT;
            cnt_q      <= '0;
            colour_q   <= 12'h000;
            target_q   <= 1'b0;
            self_hit_q <= 1'b0;
`ifdef SNAKE_WIN_ANIM_EN
            anim_q     <= 4'd0;
`endif
        end else begin
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            len_q      <= len_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            colour_q   <= colour_d;
            target_q   <= target_d;
            self_hit_q <= self_hit_d;
`ifdef SNAKE_WIN_ANIM_EN
            anim_q     <= anim_d;
`endif
        end
    end

    assign COLOUR_OUT     = colour_q;
    assign TARGET_REACHED = target_q;
    assign SELF_HIT       = self_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_pixel_renderer
// Brief    : Self-checking bench for snake_pixel_renderer (MOVE_PERIOD=4).
// Revision : 1.0
// ============================================================================
module tb_snake_pixel_renderer;

    localparam int MAXL   = 32;
    localparam int STARTL = 4;
    localparam int PERIOD = 4;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_WIN  = 2'b10;
    localparam logic [1:0] S_LOSE = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  msm, nav;
    logic [7:0]  tx;
    logic [6:0]  ty;
    logic [9:0]  ah, ay;
    logic [11:0] colour;
    logic        tr, sh;

    always #5 clk = ~clk;

    snake_pixel_renderer #(
        .MAX_LENGTH  (MAXL),
        .START_LENGTH(STARTL),
        .MOVE_PERIOD (PERIOD),
        .START_X     (80),
        .START_Y     (60)
    ) dut (
        .CLK           (clk),
        .RESET_N       (rst_n),
        .MSM_STATE     (msm),
        .NAV_STATE     (nav),
        .TARGET_X      (tx),
        .TARGET_Y      (ty),
        .ADDRH         (ah),
        .ADDRY         (ay),
        .COLOUR_OUT    (colour),
        .TARGET_REACHED(tr),
        .SELF_HIT      (sh)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: body as a queue of cells, head first.
    int   mx[$];
    int   my[$];
    int   mlen, mdir, mcnt;
    logic m_stepped;
    logic [11:0] e_col;
    logic e_tr, e_sh;

    typedef struct {
        logic [1:0]  m;
        int          ax;
        int          ayy;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mx.delete();
        my.delete();
        for (int i = 0; i < MAXL; i++) begin
            mx.push_back(((80 - i) % 160 + 160) % 160);
            my.push_back(60);
        end
        mlen = STARTL;
        mdir = 1;
        mcnt = 0;
    endfunction

    function automatic int model_colour(input int m, input int ax, input int ayy);
        int cx, cy;
        if (ax >= 640 || ayy >= 480) return 0;
        case (m)
            0: return 'h00F;
            2: return 'hFFF;
            3: return 'hF00;
            default: begin
                cx = ax / 4;
                cy = ayy / 4;
                for (int i = 0; i < mlen; i++)
                    if (mx[i] == cx && my[i] == cy) return 'hFF0;
                if (cx == int'(tx) && cy == int'(ty)) return 'hF00;
                return 'h0F0;
            end
        endcase
    endfunction

    function automatic void model_update(input int m, input int n);
        int nd, nx, ny;
        e_tr = 1'b0;
        e_sh = 1'b0;
        m_stepped = 1'b0;
        if (m == 0) begin
            model_reset();
        end else if (m == 1) begin
            if (mcnt == PERIOD - 1) begin
                mcnt = 0;
                m_stepped = 1'b1;
                nd = ((n + 2) % 4 == mdir) ? mdir : n;
                mdir = nd;
                nx = mx[0];
                ny = my[0];
                if (nd == 0) ny = (ny + 119) % 120;
                if (nd == 2) ny = (ny + 1) % 120;
                if (nd == 1) nx = (nx + 1) % 160;
                if (nd == 3) nx = (nx + 159) % 160;
                for (int i = 0; i <= mlen - 2; i++)
                    if (mx[i] == nx && my[i] == ny) e_sh = 1'b1;
                e_tr = (nx == int'(tx)) && (ny == int'(ty));
                mx.push_front(nx);
                my.push_front(ny);
                void'(mx.pop_back());
                void'(my.pop_back());
                if (e_tr && mlen < MAXL) mlen++;
            end else begin
                mcnt++;
            end
        end
    endfunction

    task automatic cycle(input logic [1:0] m, input logic [1:0] n, input int ax, input int ayy);
        msm = m;
        nav = n;
        ah  = 10'(ax);
        ay  = 10'(ayy);
        e_col = 12'(model_colour(int'(m), ax, ayy));
        model_update(int'(m), int'(n));
        @(posedge clk);
        #1;
        check("colour", colour, e_col);
        check("target_pulse", tr, e_tr);
        check("self_hit", sh, e_sh);
    endtask

    task automatic step_with(input logic [1:0] n, input int ax, input int ayy);
        for (int k = 0; k < PERIOD; k++) begin
            cycle(S_PLAY, n, ax, ayy);
            if (m_stepped) break;
        end
    endtask

    initial begin
        vecs[0]  = '{S_IDLE,   0,   0, 12'h00F};
        vecs[1]  = '{S_IDLE, 700,   0, 12'h000};
        vecs[2]  = '{S_LOSE, 100, 100, 12'hF00};
        vecs[3]  = '{S_WIN,  320, 240, 12'hFFF};
        vecs[4]  = '{S_WIN,    0, 480, 12'h000};
        vecs[5]  = '{S_PLAY, 320, 240, 12'hFF0};
        vecs[6]  = '{S_PLAY, 308, 243, 12'hFF0};
        vecs[7]  = '{S_PLAY, 304, 240, 12'h0F0};
        vecs[8]  = '{S_IDLE,  40,  40, 12'h00F};
        vecs[9]  = '{S_PLAY,  40,  40, 12'hF00};
        vecs[10] = '{S_PLAY, 639, 479, 12'h0F0};
        vecs[11] = '{S_LOSE, 639, 479, 12'hF00};
        vecs[12] = '{S_IDLE, 640, 100, 12'h000};

        rst_n = 1'b0;
        msm = S_IDLE; nav = 2'b01; tx = 8'd10; ty = 7'd10; ah = '0; ay = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_colour", colour, 12'h000);
        check("reset_target", tr, 1'b0);
        check("reset_self", sh, 1'b0);
        rst_n = 1'b1;

        for (int v = 0; v < 13; v++) begin
            cycle(vecs[v].m, 2'b01, vecs[v].ax, vecs[v].ayy);
            check("table_colour", colour, vecs[v].exp);
        end

        // Asynchronous reset in the middle of PLAY.
        cycle(S_PLAY, 2'b01, 320, 240);
        cycle(S_PLAY, 2'b01, 320, 240);
        check("play_head_pre_reset", colour, 12'hFF0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_colour", colour, 12'h000);
        check("async_rst_target", tr, 1'b0);
        check("async_rst_self", sh, 1'b0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        cycle(S_PLAY, 2'b01, 320, 240);
        check("post_rst_head", colour, 12'hFF0);

        // One step right.
        cycle(S_IDLE, 2'b01, 0, 0);
        repeat (4) cycle(S_PLAY, 2'b01, 320, 240);
        cycle(S_PLAY, 2'b01, 324, 240);
        check("step_new_head", colour, 12'hFF0);
        cycle(S_PLAY, 2'b01, 304, 240);
        check("step_cell76", colour, 12'h0F0);
        cycle(S_PLAY, 2'b01, 308, 240);
        check("step_old_tail", colour, 12'h0F0);

        // Reversal request ignored for three steps.
        cycle(S_IDLE, 2'b01, 0, 0);
        repeat (12) cycle(S_PLAY, 2'b11, 332, 240);
        cycle(S_PLAY, 2'b11, 332, 240);
        check("reversal_head", colour, 12'hFF0);
        cycle(S_PLAY, 2'b11, 336, 240);
        check("reversal_ahead", colour, 12'h0F0);

        // Horizontal wrap 159 -> 0.
        cycle(S_IDLE, 2'b01, 0, 0);
        repeat (320) cycle(S_PLAY, 2'b01, 0, 0);
        cycle(S_PLAY, 2'b01, 0, 240);
        check("wrap_head", colour, 12'hFF0);
        cycle(S_PLAY, 2'b01, 636, 240);
        check("wrap_neck", colour, 12'hFF0);

        // Target hit, growth, then WIN screen.
        cycle(S_IDLE, 2'b01, 0, 0);
        tx = 8'd81; ty = 7'd60;
        repeat (3) cycle(S_PLAY, 2'b01, 320, 240);
        cycle(S_PLAY, 2'b01, 320, 240);
        check("target_pulse_hi", tr, 1'b1);
        cycle(S_PLAY, 2'b01, 308, 240);
        check("target_pulse_lo", tr, 1'b0);
        check("grown_tail", colour, 12'hFF0);
        tx = 8'd10; ty = 7'd10;
        cycle(S_WIN, 2'b01, 320, 240);
        check("win_colour", colour, 12'hFFF);

        // Self-hit with length 5: down, left, up.
        step_with(2'b10, 0, 0);
        check("self_hit_down", sh, 1'b0);
        step_with(2'b11, 0, 0);
        check("self_hit_left", sh, 1'b0);
        step_with(2'b00, 700, 0);
        check("self_hit_up", sh, 1'b1);
        check("offscreen", colour, 12'h000);
        cycle(S_PLAY, 2'b00, 700, 0);
        check("self_hit_clear", sh, 1'b0);

        // Randomized run against the model.
        cycle(S_IDLE, 2'b01, 0, 0);
        for (int r = 0; r < 3000; r++) begin
            int sel;
            logic [1:0] m;
            sel = int'($urandom_range(99));
            if (sel < 90)      m = S_PLAY;
            else if (sel < 93) m = S_WIN;
            else if (sel < 96) m = S_LOSE;
            else if (sel < 98) m = S_IDLE;
            else               m = S_PLAY;
            if ($urandom_range(3) == 0) begin
                tx = 8'((mx[0] + int'($urandom_range(2)) - 1 + 160) % 160);
                ty = 7'((my[0] + int'($urandom_range(2)) - 1 + 120) % 120);
            end
            cycle(m, 2'($urandom_range(3)), int'($urandom_range(799)), int'($urandom_range(524)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
